// File: rtl/exe_stage_mc_pkg.sv
// rtl/exe_stage_mc_pkg.sv - ALU command codes, flag indices, select codes and FSM states
package arm_exe_pkg;

    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exe_state_e;

endpackage

// File: rtl/exe_stage_mc_if.sv
// rtl/exe_stage_mc_if.sv - ID/EXE input bundle and EXE/MEM output bank of the execute stage
interface exe_stage_mc_if #(
    parameter int BIT_NUMBER = 32
);
    logic                  in_valid;
    logic                  freeze;
    logic                  flush;
    logic [3:0]            exe_cmd;
    logic                  mul_en;
    logic                  acc_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  wb_en;
    logic [3:0]            dest;
    logic [1:0]            sel_src1;
    logic [1:0]            sel_src2;
    logic [BIT_NUMBER-1:0] pc;
    logic [BIT_NUMBER-1:0] val_rn;
    logic [BIT_NUMBER-1:0] val_rm_in;
    logic [BIT_NUMBER-1:0] val_rs;
    logic [BIT_NUMBER-1:0] val_acc;
    logic [BIT_NUMBER-1:0] mem_fwd;
    logic [BIT_NUMBER-1:0] wb_fwd;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [3:0]            sr;

    logic                  busy;
    logic [BIT_NUMBER-1:0] br_addr;
    logic                  out_valid;
    logic [BIT_NUMBER-1:0] out_result;
    logic [BIT_NUMBER-1:0] out_val_rm;
    logic [3:0]            out_dest;
    logic                  out_mem_r_en;
    logic                  out_mem_w_en;
    logic                  out_wb_en;
    logic [3:0]            status;

    modport master (
        output in_valid, freeze, flush, exe_cmd, mul_en, acc_en, mem_r_en, mem_w_en,
               wb_en, dest, sel_src1, sel_src2, pc, val_rn, val_rm_in, val_rs, val_acc,
               mem_fwd, wb_fwd, imm, shift_operand, signed_imm_24, sr,
        input  busy, br_addr, out_valid, out_result, out_val_rm, out_dest,
               out_mem_r_en, out_mem_w_en, out_wb_en, status
    );

    modport slave (
        input  in_valid, freeze, flush, exe_cmd, mul_en, acc_en, mem_r_en, mem_w_en,
               wb_en, dest, sel_src1, sel_src2, pc, val_rn, val_rm_in, val_rs, val_acc,
               mem_fwd, wb_fwd, imm, shift_operand, signed_imm_24, sr,
        output busy, br_addr, out_valid, out_result, out_val_rm, out_dest,
               out_mem_r_en, out_mem_w_en, out_wb_en, status
    );
endinterface

// File: rtl/exe_stage_mc_mul.sv
// rtl/exe_stage_mc_mul.sv - iterative shift-add multiplier, MUL_BITS multiplier bits per step
module exe_iter_mul #(
    parameter int BIT_NUMBER = 32,
    parameter int MUL_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic                  i_abort,
    input  logic [BIT_NUMBER-1:0] i_a,
    input  logic [BIT_NUMBER-1:0] i_b,
    output logic [BIT_NUMBER-1:0] o_sum,
    output logic                  o_done
);
    localparam int K  = BIT_NUMBER / MUL_BITS;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = $clog2(BIT_NUMBER);

    logic [BIT_NUMBER-1:0] r_a;
    logic [BIT_NUMBER-1:0] r_b;
    logic [BIT_NUMBER-1:0] r_acc;
    logic [CW-1:0]         r_step;

    logic [BIT_NUMBER-1:0] w_digit;
    logic [BIT_NUMBER-1:0] w_pp;
    logic [SW-1:0]         w_shamt;

    // Only the low BIT_NUMBER bits of the product survive, so truncating before the shift is exact.
    assign w_digit = {{(BIT_NUMBER-MUL_BITS){1'b0}}, r_b[MUL_BITS-1:0]};
    assign w_shamt = SW'(r_step * MUL_BITS);
    assign w_pp    = (r_a * w_digit) << w_shamt;
    assign o_sum   = r_acc + w_pp;
    assign o_done  = i_step && (r_step == CW'(K-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_step <= '0;
        end else if (i_abort) begin
            r_acc  <= '0;
            r_step <= '0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_step <= '0;
        end else if (i_step) begin
            r_acc  <= o_sum;
            r_b    <= r_b >> MUL_BITS;
            r_step <= o_done ? '0 : r_step + 1'b1;
        end
    end
endmodule

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - multi-cycle ARM execute stage: forwarding, val2, ALU, iterative MUL/MLA,
// registered EXE/MEM bank with valid/freeze/flush handshake
module exe_stage_mc
    import arm_exe_pkg::*;
#(
    parameter int BIT_NUMBER = 32,
    parameter int MUL_BITS   = 4
) (
    input  logic         clk,
    input  logic         rst,
    exe_stage_mc_if.slave bus
);
    localparam int BN = BIT_NUMBER;

    exe_state_e      r_state;
    logic            r_out_valid;
    logic [BN-1:0]   r_out_result;
    logic [BN-1:0]   r_out_val_rm;
    logic [3:0]      r_out_dest;
    logic            r_out_mem_r_en;
    logic            r_out_mem_w_en;
    logic            r_out_wb_en;
    logic [3:0]      r_status;
    logic [BN-1:0]   r_mul_acc;
    logic            r_mul_acc_en;
    logic [1:0]      r_mul_cv;
    logic [3:0]      r_mul_dest;
    logic            r_mul_wb_en;

    logic [BN-1:0]   w_val1;
    logic [BN-1:0]   w_val_rm;
    logic [BN-1:0]   w_val2;
    logic [BN-1:0]   w_imm8_ext;
    logic [2*BN-1:0] w_rot_imm;
    logic [2*BN-1:0] w_rot_rm;
    logic [4:0]      w_sh_amt;
    logic [BN:0]     w_sum;
    logic [BN-1:0]   w_alu_res;
    logic            w_alu_c;
    logic            w_alu_v;
    logic            w_cin;
    logic [BN-1:0]   w_mul_sum;
    logic [BN-1:0]   w_mul_res;
    logic            w_mul_done;
    logic            w_idle_go;
    logic            w_mul_start;
    logic            w_mul_step;

    always_comb begin
        case (bus.sel_src1)
            SEL_MEM: w_val1 = bus.mem_fwd;
            SEL_WB:  w_val1 = bus.wb_fwd;
            default: w_val1 = bus.val_rn;
        endcase
        case (bus.sel_src2)
            SEL_MEM: w_val_rm = bus.mem_fwd;
            SEL_WB:  w_val_rm = bus.wb_fwd;
            default: w_val_rm = bus.val_rm_in;
        endcase
    end

    assign w_imm8_ext = {{(BN-8){1'b0}}, bus.shift_operand[7:0]};
    assign w_rot_imm  = {w_imm8_ext, w_imm8_ext} >> {bus.shift_operand[11:8], 1'b0};
    assign w_rot_rm   = {w_val_rm, w_val_rm} >> bus.shift_operand[11:7];
    assign w_sh_amt   = bus.shift_operand[11:7];

    // Loads/stores use the raw 12-bit unsigned offset; no rotate or register shift applies.
    always_comb begin
        w_val2 = '0;
        if (bus.mem_r_en || bus.mem_w_en) begin
            w_val2 = {{(BN-12){1'b0}}, bus.shift_operand};
        end else if (bus.imm) begin
            w_val2 = w_rot_imm[BN-1:0];
        end else begin
            case (bus.shift_operand[6:5])
                2'b00:   w_val2 = w_val_rm << w_sh_amt;
                2'b01:   w_val2 = w_val_rm >> w_sh_amt;
                2'b10:   w_val2 = $signed(w_val_rm) >>> w_sh_amt;
                default: w_val2 = w_rot_rm[BN-1:0];
            endcase
        end
    end

    assign w_cin = bus.sr[FLAG_C];

    // Subtract carry follows ARM: C = 1 means no borrow.
    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_alu_c   = bus.sr[FLAG_C];
        w_alu_v   = bus.sr[FLAG_V];
        case (bus.exe_cmd)
            EXE_CMD_MOV: w_alu_res = w_val2;
            EXE_CMD_MVN: w_alu_res = ~w_val2;
            EXE_CMD_ADD, EXE_CMD_ADC: begin
                w_sum     = {1'b0, w_val1} + {1'b0, w_val2}
                          + ((bus.exe_cmd == EXE_CMD_ADC) ? (BN+1)'(w_cin) : '0);
                w_alu_res = w_sum[BN-1:0];
                w_alu_c   = w_sum[BN];
                w_alu_v   = (w_val1[BN-1] == w_val2[BN-1]) && (w_alu_res[BN-1] != w_val1[BN-1]);
            end
            EXE_CMD_SUB, EXE_CMD_SBC: begin
                w_sum     = {1'b0, w_val1} - {1'b0, w_val2}
                          - ((bus.exe_cmd == EXE_CMD_SBC) ? (BN+1)'(!w_cin) : '0);
                w_alu_res = w_sum[BN-1:0];
                w_alu_c   = !w_sum[BN];
                w_alu_v   = (w_val1[BN-1] != w_val2[BN-1]) && (w_alu_res[BN-1] != w_val1[BN-1]);
            end
            EXE_CMD_AND: w_alu_res = w_val1 & w_val2;
            EXE_CMD_ORR: w_alu_res = w_val1 | w_val2;
            EXE_CMD_EOR: w_alu_res = w_val1 ^ w_val2;
            default:     w_alu_res = '0;
        endcase
    end

    assign w_idle_go   = (r_state == IDLE) && bus.in_valid && !bus.freeze && !bus.flush;
    assign w_mul_start = w_idle_go && bus.mul_en;
    assign w_mul_step  = (r_state == MUL) && !bus.freeze && !bus.flush;
    assign w_mul_res   = w_mul_sum + (r_mul_acc_en ? r_mul_acc : '0);

    exe_iter_mul #(
        .BIT_NUMBER(BIT_NUMBER),
        .MUL_BITS  (MUL_BITS)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_mul_start),
        .i_step (w_mul_step),
        .i_abort(bus.flush),
        .i_a    (w_val1),
        .i_b    (bus.val_rs),
        .o_sum  (w_mul_sum),
        .o_done (w_mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_val_rm   <= '0;
            r_out_dest     <= '0;
            r_out_mem_r_en <= 1'b0;
            r_out_mem_w_en <= 1'b0;
            r_out_wb_en    <= 1'b0;
            r_status       <= '0;
            r_mul_acc      <= '0;
            r_mul_acc_en   <= 1'b0;
            r_mul_cv       <= '0;
            r_mul_dest     <= '0;
            r_mul_wb_en    <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
        end else if (!bus.freeze) begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    if (w_idle_go && !bus.mul_en) begin
                        r_out_valid    <= 1'b1;
                        r_out_result   <= w_alu_res;
                        r_out_val_rm   <= w_val_rm;
                        r_out_dest     <= bus.dest;
                        r_out_mem_r_en <= bus.mem_r_en;
                        r_out_mem_w_en <= bus.mem_w_en;
                        r_out_wb_en    <= bus.wb_en;
                        r_status       <= {w_alu_res[BN-1], (w_alu_res == '0), w_alu_c, w_alu_v};
                    end else if (w_mul_start) begin
                        r_state      <= MUL;
                        r_mul_acc    <= bus.val_acc;
                        r_mul_acc_en <= bus.acc_en;
                        r_mul_cv     <= {bus.sr[FLAG_C], bus.sr[FLAG_V]};
                        r_mul_dest   <= bus.dest;
                        r_mul_wb_en  <= bus.wb_en;
                    end
                end
                MUL: begin
                    r_out_valid <= 1'b0;
                    if (w_mul_done) begin
                        r_state        <= IDLE;
                        r_out_valid    <= 1'b1;
                        r_out_result   <= w_mul_res;
                        r_out_val_rm   <= '0;
                        r_out_dest     <= r_mul_dest;
                        r_out_mem_r_en <= 1'b0;
                        r_out_mem_w_en <= 1'b0;
                        r_out_wb_en    <= r_mul_wb_en;
                        r_status       <= {w_mul_res[BN-1], (w_mul_res == '0), r_mul_cv};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (r_state == MUL);
    assign bus.br_addr      = bus.pc + ({{(BN-24){bus.signed_imm_24[23]}}, bus.signed_imm_24} << 2);
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_out_result;
    assign bus.out_val_rm   = r_out_val_rm;
    assign bus.out_dest     = r_out_dest;
    assign bus.out_mem_r_en = r_out_mem_r_en;
    assign bus.out_mem_w_en = r_out_mem_w_en;
    assign bus.out_wb_en    = r_out_wb_en;
    assign bus.status       = r_status;
endmodule
